// File: rtl/pe_sum_seq.sv
// PE accumulation sequencer: walks taps/outputs and drives sum-stage control.
// Optional PE_STALL_CNT_EN adds a saturating 16-bit stall-cycle counter.
module pe_sum_seq #(
   parameter int TapWd = 8,
   parameter int OutWd = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [TapWd-1:0] i_cfg_taps,
   input  logic [OutWd-1:0] i_cfg_outs,
   input  logic             i_cfg_init,
   input  logic             i_start,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic             i_psum_ready,
   output logic             o_psum_wr,
   output logic             o_ctl_reset,
   output logic             o_ctl_stall,
   output logic             o_ctl_valid,
   output logic             o_ctl_init,
   output logic             o_ctl_fstpix,
   output logic             o_ctl_lstpix,
   output logic [TapWd-1:0] o_tap_idx,
   output logic [OutWd-1:0] o_out_idx,
   output logic             o_busy,
`ifdef PE_STALL_CNT_EN
   output logic [15:0]      o_stall_cnt,
`endif
   output logic             o_done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t state_q, state_d;

   logic [TapWd-1:0] taps_m1_q, tap_q;
   logic [OutWd-1:0] outs_m1_q, out_q;
   logic             init_q;
   logic             wr_pend_q;

   logic run, drain, start_ok, beat;
   logic last_tap, last_out, lst_beat, ctl_stall;

   assign run      = state_q == S_RUN;
   assign drain    = state_q == S_DRAIN;
   assign start_ok = (state_q == S_IDLE) && i_start;
   assign last_tap = tap_q == taps_m1_q;
   assign last_out = out_q == outs_m1_q;

   assign o_in_ready = run && (!wr_pend_q || i_psum_ready);
   assign beat       = i_in_valid && o_in_ready;
   assign lst_beat   = beat && last_tap;
   assign ctl_stall  = (run && !beat) || (wr_pend_q && !i_psum_ready);

   assign o_ctl_valid  = beat;
   assign o_ctl_fstpix = beat && (tap_q == '0);
   assign o_ctl_lstpix = lst_beat;
   assign o_ctl_init   = o_ctl_fstpix && init_q;
   assign o_ctl_stall  = ctl_stall;
   assign o_ctl_reset  = start_ok;
   assign o_psum_wr    = wr_pend_q;
   assign o_busy       = state_q != S_IDLE;
   assign o_done       = state_q == S_DONE;
   assign o_tap_idx    = (run || drain) ? tap_q : '0;
   assign o_out_idx    = (run || drain) ? out_q : '0;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (i_start) state_d = S_RUN;
         S_RUN:   if (lst_beat && last_out) state_d = S_DRAIN;
         S_DRAIN: if (!wr_pend_q || i_psum_ready) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // zero-length configs behave as length one
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         taps_m1_q <= '0;
         outs_m1_q <= '0;
         init_q    <= 1'b0;
         tap_q     <= '0;
         out_q     <= '0;
      end else if (start_ok) begin
         taps_m1_q <= (i_cfg_taps == '0) ? '0 : i_cfg_taps - TapWd'(1);
         outs_m1_q <= (i_cfg_outs == '0) ? '0 : i_cfg_outs - OutWd'(1);
         init_q    <= i_cfg_init;
         tap_q     <= '0;
         out_q     <= '0;
      end else if (beat) begin
         if (!last_tap) begin
            tap_q <= tap_q + TapWd'(1);
         end else if (!last_out) begin
            tap_q <= '0;
            out_q <= out_q + OutWd'(1);
         end
      end
   end

   // a fresh lstpix beat keeps the write pending even if the pad accepts
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_pend_q <= 1'b0;
      end else if (lst_beat) begin
         wr_pend_q <= 1'b1;
      end else if (i_psum_ready) begin
         wr_pend_q <= 1'b0;
      end
   end

`ifdef PE_STALL_CNT_EN
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_stall_cnt <= '0;
      end else if (start_ok) begin
         o_stall_cnt <= '0;
      end else if (o_busy && ctl_stall && (o_stall_cnt != 16'hFFFF)) begin
         o_stall_cnt <= o_stall_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pe_sum_seq.sv
// Scoreboard bench for pe_sum_seq: expected beats queued per job,
// popped as the sequencer issues sum-stage beats.
module tb_pe_sum_seq;

   localparam int TW = 8;
   localparam int OW = 8;

   logic          clk;
   logic          rst;
   logic [TW-1:0] cfg_taps;
   logic [OW-1:0] cfg_outs;
   logic          cfg_init;
   logic          start;
   logic          in_valid;
   logic          in_ready;
   logic          psum_ready;
   logic          psum_wr;
   logic          ctl_reset;
   logic          ctl_stall;
   logic          ctl_valid;
   logic          ctl_init;
   logic          ctl_fstpix;
   logic          ctl_lstpix;
   logic [TW-1:0] tap_idx;
   logic [OW-1:0] out_idx;
   logic          busy;
   logic          done;
`ifdef PE_STALL_CNT_EN
   logic [15:0]   stall_cnt;
`endif

   pe_sum_seq #(.TapWd(TW), .OutWd(OW)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_cfg_taps   (cfg_taps),
      .i_cfg_outs   (cfg_outs),
      .i_cfg_init   (cfg_init),
      .i_start      (start),
      .i_in_valid   (in_valid),
      .o_in_ready   (in_ready),
      .i_psum_ready (psum_ready),
      .o_psum_wr    (psum_wr),
      .o_ctl_reset  (ctl_reset),
      .o_ctl_stall  (ctl_stall),
      .o_ctl_valid  (ctl_valid),
      .o_ctl_init   (ctl_init),
      .o_ctl_fstpix (ctl_fstpix),
      .o_ctl_lstpix (ctl_lstpix),
      .o_tap_idx    (tap_idx),
      .o_out_idx    (out_idx),
      .o_busy       (busy),
`ifdef PE_STALL_CNT_EN
      .o_stall_cnt  (stall_cnt),
`endif
      .o_done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit fst;
      bit lst;
      bit ini;
      int tap;
      int out;
   } beat_t;

   beat_t beat_q[$];
   beat_t mon_e;
   int    wr_cyc[$];
   int    tests = 0;
   int    fails = 0;
   int    cyc = 0;
   int    wr_cnt, done_cnt, stall_seen;
   int    fb_cyc, lb_cyc, done_cyc;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (ctl_valid) begin
            if (beat_q.size() == 0) begin
               check("extra_beat", 1, 0);
            end else begin
               mon_e = beat_q.pop_front();
               check("fstpix", ctl_fstpix, mon_e.fst);
               check("lstpix", ctl_lstpix, mon_e.lst);
               check("init", ctl_init, mon_e.ini);
               check("tap_idx", tap_idx, mon_e.tap);
               check("out_idx", out_idx, mon_e.out);
            end
            if (fb_cyc < 0) fb_cyc = cyc;
            lb_cyc = cyc;
         end
         if (psum_wr && psum_ready) begin
            wr_cnt++;
            wr_cyc.push_back(cyc);
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (busy && ctl_stall) stall_seen++;
      end
   end

   // mode 0 steady, 1 pad backpressure, 2 valid toggling, 4 start while busy
   task automatic run_job(input int taps, input int outs, input bit ini,
                          input int mode, input int exp_stall);
      int et, eo, n, hold;
      bit dropped;
      beat_t b;
      et = (taps == 0) ? 1 : taps;
      eo = (outs == 0) ? 1 : outs;
      for (int o = 0; o < eo; o++) begin
         for (int t = 0; t < et; t++) begin
            b.fst = (t == 0);
            b.lst = (t == et - 1);
            b.ini = (t == 0) && ini;
            b.tap = t;
            b.out = o;
            beat_q.push_back(b);
         end
      end
      wr_cnt = 0;
      done_cnt = 0;
      stall_seen = 0;
      fb_cyc = -1;
      lb_cyc = -1;
      done_cyc = -1;
      wr_cyc.delete();
      @(posedge clk); #1;
      cfg_taps = TW'(taps);
      cfg_outs = OW'(outs);
      cfg_init = ini;
      start = 1'b1;
      in_valid = 1'b1;
      psum_ready = 1'b1;
      #1 check("ctl_reset", ctl_reset, 1);
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      hold = 0;
      dropped = 1'b0;
      while (done_cnt == 0 && n < 300) begin
         case (mode)
            1: begin
               if (hold > 0) begin
                  check("bp_ready", in_ready, 0);
                  check("bp_stall", ctl_stall, 1);
                  check("bp_tap", tap_idx, 0);
                  hold--;
                  if (hold == 0) psum_ready = 1'b1;
               end else if (!dropped && psum_wr) begin
                  dropped = 1'b1;
                  psum_ready = 1'b0;
                  hold = 3;
               end
            end
            2: in_valid = (n % 2 == 0);
            4: begin
               if (n == 1) begin
                  start = 1'b1;
                  cfg_taps = 1;
                  cfg_outs = 1;
                  cfg_init = ~ini;
                  #1 check("busy_start", ctl_reset, 0);
               end else if (n == 2) begin
                  start = 1'b0;
                  cfg_taps = TW'(taps);
                  cfg_outs = OW'(outs);
                  cfg_init = ini;
               end
            end
            default: ;
         endcase
         @(posedge clk); #1;
         n++;
      end
      check("done_seen", done_cnt, 1);
      repeat (3) @(posedge clk);
      #1;
      check("done_once", done_cnt, 1);
      check("writes", wr_cnt, eo);
      check("beats_left", beat_q.size(), 0);
      check("stalls", stall_seen, exp_stall);
      check("idle", busy, 0);
`ifdef PE_STALL_CNT_EN
      check("stall_cnt", stall_cnt, exp_stall);
`endif
      beat_q.delete();
      in_valid = 1'b0;
   endtask

   initial begin
      int n;
      rst = 1'b1;
      cfg_taps = '0;
      cfg_outs = '0;
      cfg_init = 1'b0;
      start = 1'b0;
      in_valid = 1'b0;
      psum_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_ready", in_ready, 0);
      check("rst_wr", psum_wr, 0);
      check("rst_done", done, 0);
      check("rst_stall", ctl_stall, 0);
      check("rst_tap", tap_idx, 0);
      rst = 1'b0;

      run_job(3, 2, 1'b1, 0, 0);
      check("t1_wrn", wr_cyc.size(), 2);
      if (wr_cyc.size() == 2) begin
         check("t1_wr0", wr_cyc[0] - fb_cyc, 3);
         check("t1_wr1", wr_cyc[1] - fb_cyc, 6);
      end
      check("t1_done", done_cyc - lb_cyc, 2);

      run_job(1, 4, 1'b1, 0, 0);
      check("t2_wrn", wr_cyc.size(), 4);
      if (wr_cyc.size() == 4) check("t2_burst", wr_cyc[3] - wr_cyc[0], 3);

      run_job(2, 2, 1'b1, 1, 3);
      run_job(4, 1, 1'b0, 2, 3);

      b_rst_job();

      run_job(2, 3, 1'b1, 0, 0);
      run_job(3, 2, 1'b1, 4, 0);
      run_job(0, 0, 1'b1, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   task automatic b_rst_job();
      int n;
      beat_t b;
      for (int o = 0; o < 3; o++) begin
         for (int t = 0; t < 3; t++) begin
            b.fst = (t == 0);
            b.lst = (t == 2);
            b.ini = (t == 0);
            b.tap = t;
            b.out = o;
            beat_q.push_back(b);
         end
      end
      @(posedge clk); #1;
      cfg_taps = 3;
      cfg_outs = 3;
      cfg_init = 1'b1;
      start = 1'b1;
      in_valid = 1'b1;
      psum_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      while (out_idx != 1 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check("rst_reach", out_idx, 1);
      rst = 1'b1;
      #1;
      check("abort_busy", busy, 0);
      check("abort_ready", in_ready, 0);
      check("abort_wr", psum_wr, 0);
      check("abort_valid", ctl_valid, 0);
      check("abort_stall", ctl_stall, 0);
      check("abort_out", out_idx, 0);
      check("abort_done", done, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      in_valid = 1'b0;
      beat_q.delete();
   endtask

endmodule
